// File: rtl/maxpool2x2_if.sv
// Stream bundle between the ReLU stage, the pooling stage and its consumer.
// Latency: none, wires only.
// Backpressure: none; valid-only stream, the consumer must take every beat.
interface maxpool2x2_if #(
  parameter int NUM_WIDTH = 16
);
  logic                 up_valid;
  logic [NUM_WIDTH-1:0] up_data;
  logic                 dn_valid;
  logic [NUM_WIDTH-1:0] dn_data;

  // Source side: drives samples in, observes pooled results.
  modport master (output up_valid, up_data, input dn_valid, dn_data);
  // Pooling stage side.
  modport slave  (input up_valid, up_data, output dn_valid, dn_data);
endinterface

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a raster stream, one pooled row held in a line buffer; bypass passes samples through.
// Latency: 1 cycle from the accepting edge of a window's 4th sample (or of a bypassed sample) to dn_valid.
// Backpressure: none; up_valid gaps stall the counters, and every dn_valid beat must be taken.
module maxpool2x2 #(
  parameter int NUM_WIDTH = 16,
  parameter int MAX_COLS  = 64,
  parameter int DIM_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bypass,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic [DIM_W-1:0] cfg_rows,
  maxpool2x2_if.slave      bus,
  output logic             frame_done,
  output logic             busy
);
  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  // Raw column count is kept so an odd trailing column is still consumed and dropped.
  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-2:0] rows_half_q;
  logic [DIM_W-1:0] col_cnt, row_cnt;
  logic signed [NUM_WIDTH-1:0] pair_q;
  logic signed [NUM_WIDTH-1:0] linebuf [LB_DEPTH];

  logic [DIM_W-1:0] cols_ev, rows_ev;
  logic cfg_short, accept, last_col, last_row, pool_col;
  logic win, win_out, win_last;
  logic signed [NUM_WIDTH-1:0] sample, pmax, lb_rd, result;

  assign sample    = bus.up_data;
  assign cols_ev   = {cols_q[DIM_W-1:1], 1'b0};
  assign rows_ev   = {rows_half_q, 1'b0};
  // Fewer than 2 columns or rows after rounding down means no window exists.
  assign cfg_short = (cfg_cols < DIM_W'(2)) || (cfg_rows < DIM_W'(2));
  // A start in the same cycle wins over any sample.
  assign accept    = (state == RUN) && bus.up_valid && !bypass && !start;
  assign last_col  = (col_cnt == cols_q - DIM_W'(1));
  assign last_row  = (row_cnt == rows_ev - DIM_W'(1));
  assign pool_col  = (col_cnt < cols_ev);
  assign win       = accept && pool_col && col_cnt[0];
  assign win_out   = win && row_cnt[0];
  assign win_last  = win_out && last_row && (col_cnt == cols_ev - DIM_W'(1));
  assign lb_rd     = linebuf[col_cnt[LB_AW:1]];
  assign pmax      = (sample > pair_q) ? sample : pair_q;
  assign result    = (pmax > lb_rd) ? pmax : lb_rd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start (re)launches a frame unless it is degenerate; the last raw column of the last pooled row ends it.
  always_comb begin
    state_nxt = state;
    if (start)                                state_nxt = cfg_short ? IDLE : RUN;
    else if (accept && last_col && last_row)  state_nxt = IDLE;
  end

  // State outputs.
  always_comb begin
    busy = (state == RUN);
  end

  // Config latch, raster counters and the horizontal pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q      <= '0;
      rows_half_q <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      pair_q      <= '0;
    end else if (start) begin
      cols_q      <= cfg_cols;
      rows_half_q <= cfg_rows[DIM_W-1:1];
      col_cnt     <= '0;
      row_cnt     <= '0;
      pair_q      <= '0;
    end else if (accept) begin
      if (!col_cnt[0]) pair_q <= sample;
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + DIM_W'(1);
      end else begin
        col_cnt <= col_cnt + DIM_W'(1);
      end
    end
  end

  // Even rows park their horizontal pair maxima for the odd row below.
  always_ff @(posedge clk) begin
    if (win && !row_cnt[0]) linebuf[col_cnt[LB_AW:1]] <= pmax;
  end

  // Registered output stage; dn_data holds between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dn_valid <= 1'b0;
      bus.dn_data  <= '0;
      frame_done   <= 1'b0;
    end else if (bypass) begin
      bus.dn_valid <= bus.up_valid;
      if (bus.up_valid) bus.dn_data <= bus.up_data;
      frame_done   <= start && cfg_short;
    end else begin
      bus.dn_valid <= win_out;
      if (win_out) bus.dn_data <= result;
      frame_done   <= win_last || (start && cfg_short);
    end
  end
endmodule

// File: tb/tb_maxpool2x2.sv
// Bench for maxpool2x2: directed frames checked against a window-level model plus literal spot checks.
// Inputs change on the falling edge, outputs are sampled on the falling edge after the accepting rising edge.
// Every output beat is matched in order against an expectation queue filled by the model.
module tb_maxpool2x2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bypass = 1'b0;
  logic       start = 1'b0;
  logic [6:0] cfg_cols = '0;
  logic [6:0] cfg_rows = '0;
  logic       frame_done;
  logic       busy;

  maxpool2x2_if #(.NUM_WIDTH(16)) bus ();

  maxpool2x2 #(.NUM_WIDTH(16), .MAX_COLS(64), .DIM_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .bypass(bypass), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .bus(bus),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] dat;
    logic        fd;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int n_vec = 0;
  int n_bad = 0;

  // Model state: the frame as a flat raster array, indexed by accepted sample number.
  logic [15:0] fr [0:8191];
  int m_cols = 0, m_cev = 0, m_rev = 0, m_idx = 0;
  bit m_active = 1'b0;

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic start_frame(input int c, input int r);
    start = 1'b1;
    cfg_cols = 7'(c);
    cfg_rows = 7'(r);
    bus.up_valid = 1'b0;
    m_cols = c;
    m_cev = c & ~1;
    m_rev = r & ~1;
    m_idx = 0;
    m_active = (m_cev >= 2) && (m_rev >= 2);
    if (!m_active) expq.push_back('{1'b0, 16'h0000, 1'b1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [15:0] d, input logic byp);
    int r, c;
    logic [15:0] w;
    bus.up_valid = v;
    bus.up_data = d;
    bypass = byp;
    if (v && byp) begin
      expq.push_back('{1'b1, d, 1'b0});
    end else if (v && m_active) begin
      fr[m_idx] = d;
      r = m_idx / m_cols;
      c = m_idx % m_cols;
      if ((r % 2 == 1) && (c % 2 == 1) && (c < m_cev) && (r < m_rev)) begin
        w = smax(smax(fr[(r-1)*m_cols + c-1], fr[(r-1)*m_cols + c]),
                 smax(fr[r*m_cols + c-1],     fr[r*m_cols + c]));
        expq.push_back('{1'b1, w, (r == m_rev-1) && (c == m_cev-1)});
      end
      m_idx++;
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
    chk(nm, expq.size(), 0);
    expq.delete();
  endtask

  // In-order compare of every output beat against the model queue.
  always @(negedge clk) begin
    if (rst_n && (bus.dn_valid === 1'b1 || frame_done === 1'b1)) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got valid=%0b data=0x%0h frame_done=%0b, expected no output",
                 bus.dn_valid, bus.dn_data, frame_done);
      end else begin
        e = expq.pop_front();
        chk("stream_valid", {31'b0, bus.dn_valid}, {31'b0, e.vld});
        if (e.vld) chk("stream_data", {16'b0, bus.dn_data}, {16'b0, e.dat});
        chk("stream_frame_done", {31'b0, frame_done}, {31'b0, e.fd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    #1;
    chk("reset_dn_valid", {31'b0, bus.dn_valid}, 0);
    chk("reset_dn_data", {16'b0, bus.dn_data}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_frame_done", {31'b0, frame_done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 contiguous 0..15 -> 5,7,13,15, each one cycle after its last sample.
    start_frame(4, 4);
    chk("t1_busy_after_start", {31'b0, busy}, 1);
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 16'(i), 1'b0);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        chk("t1_out_valid", {31'b0, bus.dn_valid}, 1);
        chk("t1_out_data", {16'b0, bus.dn_data}, 32'(i));
        chk("t1_out_fd", {31'b0, frame_done}, (i == 15) ? 1 : 0);
      end else begin
        chk("t1_no_out", {31'b0, bus.dn_valid}, 0);
      end
      if (i == 14) chk("t1_busy_before_last", {31'b0, busy}, 1);
      if (i == 15) chk("t1_busy_after_last", {31'b0, busy}, 0);
    end
    drain("t1_drain");

    // Signed 2x2: FFFF is the largest of the four.
    start_frame(2, 2);
    send(1'b1, 16'hFFFF, 1'b0);
    send(1'b1, 16'h8000, 1'b0);
    send(1'b1, 16'hFFFE, 1'b0);
    send(1'b1, 16'h8001, 1'b0);
    chk("signed_valid", {31'b0, bus.dn_valid}, 1);
    chk("signed_data", {16'b0, bus.dn_data}, 32'hFFFF);
    chk("signed_fd", {31'b0, frame_done}, 1);
    drain("signed_drain");

    // 4x4 with random valid gaps carrying junk data.
    start_frame(4, 4);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) send(1'b0, 16'h7EAD, 1'b0);
      send(1'b1, 16'(i), 1'b0);
    end
    chk("gaps_busy_after_last", {31'b0, busy}, 0);
    chk("gaps_last_data", {16'b0, bus.dn_data}, 32'd15);
    drain("gaps_drain");

    // Bypass echo in IDLE, then data hold while valid is low.
    send(1'b1, 16'h1234, 1'b1);
    chk("byp_valid0", {31'b0, bus.dn_valid}, 1);
    chk("byp_data0", {16'b0, bus.dn_data}, 32'h1234);
    send(1'b1, 16'hF000, 1'b1);
    chk("byp_data1", {16'b0, bus.dn_data}, 32'hF000);
    send(1'b0, 16'h0BAD, 1'b1);
    chk("byp_idle_valid", {31'b0, bus.dn_valid}, 0);
    chk("byp_hold_data", {16'b0, bus.dn_data}, 32'hF000);
    send(1'b0, 16'h0000, 1'b0);
    drain("byp_drain");

    // Bypass inserted mid-frame after sample 6; pooling resumes unchanged.
    start_frame(4, 4);
    for (int i = 0; i < 7; i++) send(1'b1, 16'(i), 1'b0);
    send(1'b1, 16'hAAAA, 1'b1);
    send(1'b0, 16'h0000, 1'b1);
    send(1'b1, 16'h5555, 1'b1);
    chk("mid_byp_busy", {31'b0, busy}, 1);
    for (int i = 7; i < 16; i++) begin
      send(1'b1, 16'(i), 1'b0);
      if (i == 7) chk("mid_byp_resume_data", {16'b0, bus.dn_data}, 32'd7);
    end
    drain("mid_byp_drain");

    // Odd config 5x3: trailing column and row dropped.
    start_frame(5, 3);
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 16'(i), 1'b0);
      if (i == 6) chk("odd_out6", {15'b0, bus.dn_valid, bus.dn_data}, 32'h1_0006);
      if (i == 8) chk("odd_out8_fd", {15'b0, frame_done, bus.dn_data}, 32'h1_0008);
      if (i == 9) chk("odd_busy_end", {31'b0, busy}, 0);
    end
    drain("odd_drain");

    // Degenerate configs complete immediately without output.
    start_frame(1, 4);
    chk("degen_cols_fd", {31'b0, frame_done}, 1);
    chk("degen_cols_valid", {31'b0, bus.dn_valid}, 0);
    chk("degen_cols_busy", {31'b0, busy}, 0);
    start_frame(4, 1);
    chk("degen_rows_fd", {31'b0, frame_done}, 1);
    for (int i = 0; i < 4; i++) send(1'b1, 16'(i + 100), 1'b0);
    drain("degen_drain");

    // Abort after 6 samples, restart with a clean frame.
    start_frame(4, 4);
    for (int i = 0; i < 6; i++) send(1'b1, 16'(i + 40), 1'b0);
    start_frame(4, 4);
    for (int i = 0; i < 16; i++) send(1'b1, 16'(i), 1'b0);
    drain("abort_drain");

    // Asynchronous reset mid-frame.
    start_frame(4, 4);
    for (int i = 0; i < 6; i++) send(1'b1, 16'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    m_active = 1'b0;
    expq.delete();
    #1;
    chk("arst_dn_valid", {31'b0, bus.dn_valid}, 0);
    chk("arst_dn_data", {16'b0, bus.dn_data}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after reset.
    start_frame(2, 2);
    send(1'b1, 16'h0003, 1'b0);
    send(1'b1, 16'h8000, 1'b0);
    send(1'b1, 16'h0003, 1'b0);
    send(1'b1, 16'hFFF0, 1'b0);
    chk("post_rst_data", {16'b0, bus.dn_data}, 32'h0003);
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/maxpool2x2.md
Name: maxpool2x2

Overview:
- Downstream neighbour of the ReLU stage: consumes the ReLU result stream and performs 2x2, stride-2 max pooling over a raster-ordered feature map.
- Holds one pooled row in an internal line buffer.
- Emits one pooled value per 2x2 window on a registered valid/data output.
- A bypass mode forwards samples unchanged, so the ReLU-to-pool path can be run as a plain pipeline.

Parameters:
- NUM_WIDTH, 16: sample width, two's-complement signed.
- MAX_COLS, 64: maximum feature-map width; the line buffer depth is MAX_COLS/2.
- DIM_W, 7: width of the cfg_cols and cfg_rows fields; must satisfy 2^DIM_W > MAX_COLS.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- bypass, input, 1: when 1, pass-through mode; pooling counters frozen.
- start, input, 1: single-cycle pulse; latches cfg and begins a frame.
- cfg_cols, input, DIM_W: input columns per row; valid range 2..MAX_COLS.
- cfg_rows, input, DIM_W: input rows per frame; minimum 2.
- up_valid, input, 1: up_data carries a sample this cycle.
- up_data, input, NUM_WIDTH: input sample, raster order.
- dn_valid, output, 1: dn_data holds a result this cycle.
- dn_data, output, NUM_WIDTH: pooled or bypassed sample.
- frame_done, output, 1: one-cycle pulse marking the last pooled output of a frame.
- busy, output, 1: high while in RUN.

Behaviour:
- Reset: dn_valid=0, dn_data=0, frame_done=0, busy=0, FSM=IDLE, all counters 0. The line buffer is not cleared; it is never read before it is written within a frame.
- Config rules:
  - cfg_cols and cfg_rows are latched on start.
  - Bit 0 of each is ignored (odd values are rounded down), so the last odd column/row is dropped.
  - Latched cols < 2 or rows < 2: the frame completes immediately; frame_done pulses 1 cycle after start, with no dn_valid.
- FSM IDLE:
  - busy=0; up_valid is ignored unless bypass=1.
  - start=1 -> RUN, clearing col_cnt, row_cnt and the pair register.
- FSM RUN:
  - busy=1; each up_valid=1 sample with bypass=0 advances col_cnt.
  - At col_cnt = cols-1: col_cnt wraps to 0 and row_cnt increments.
  - After the last column of row rows-1 the FSM returns to IDLE.
- Column pairing:
  - On an even col_cnt the sample is held in the pair register.
  - On an odd col_cnt, pmax = signed max(pair register, up_data).
- Even row_cnt: pmax is written to linebuf[col_cnt>>1]; no output.
- Odd row_cnt:
  - On an odd col_cnt, result = signed max(pmax, linebuf[col_cnt>>1]).
  - The result is registered to dn_data with dn_valid=1 in the next cycle.
  - Latency is 1 cycle from the accepting edge of the window's 4th sample.
- Ties: equal values give that value.
- Comparison is signed: 16'h8000 is the minimum value and 16'h7FFF the maximum.
- frame_done: asserted in the same cycle as the dn_valid of the final window (row rows-1, col cols-1).
- Gaps: up_valid=0 cycles stall counters and state indefinitely; results do not depend on gap placement.
- Bypass=1:
  - dn_valid <= up_valid and dn_data <= up_data, 1-cycle latency.
  - FSM and counters hold their values.
  - A frame interrupted by bypass resumes exactly where it stopped when bypass returns to 0.
- Start during RUN: the frame is aborted and restarted with the new cfg. No dn_valid or frame_done from the aborted frame appears after the start edge, except an output already registered that cycle.
- Reset mid-frame: immediate return to the reset values above.
- dn_data holds its last value while dn_valid=0.

Test Plan:
- 4x4 frame, cols=4, rows=4, stream 0..15 contiguous -> dn_data 5,7,13,15 on 4 dn_valid pulses; frame_done with the 15. Each output 1 cycle after samples 5, 7, 13, 15 respectively.
- Signed check, 2x2 frame {16'hFFFF, 16'h8000, 16'hFFFE, 16'h8001} -> single output 16'hFFFF, with frame_done the same cycle.
- Same 4x4 frame with random up_valid gaps (e.g. 50% duty) -> identical output sequence 5,7,13,15; busy drops the cycle after the last sample.
- Bypass: bypass=1, up_valid pulses with data 16'h1234, 16'hF000 -> dn_valid/dn_data echo them 1 cycle later. Then bypass=0 mid-frame on the 4x4 case, with bypassed samples inserted after sample 6 -> pooled outputs still 5,7,13,15.
- Odd config: cols=5, rows=3, 15 samples 0..14 -> cols treated as 4 and rows as 2. A single frame yields outputs 6 and 8 (max of {0,1,5,6} and {2,3,7,8}, with col 4 dropped); frame_done with 8.
- Abort/reset: start mid-frame after 6 samples, then a fresh 4x4 stream 0..15 -> outputs 5,7,13,15 only. rst_n low mid-frame -> dn_valid=0, busy=0, dn_data=0 immediately (asynchronous).
